// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its scheduler: widths, opcodes
// and the scheduler FSM encoding.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int OP_W    = 4;
  localparam int NUM_OPS = 11;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: two DATA_W operands, double-width result, carry/borrow
// and signed-overflow flags for add/sub. Undefined opcodes yield all zeros.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic [DATA_W-1:0]   i0,
  input  logic [DATA_W-1:0]   i1,
  input  logic [OP_W-1:0]     op,
  output logic [2*DATA_W-1:0] o,
  output logic                overflow,
  output logic                cout
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]          zero_h;
  logic [SH_W-1:0]            sh;
  logic [DATA_W:0]            add_u, sub_u;
  logic signed [DATA_W:0]     add_s, sub_s;
  logic signed [2*DATA_W-1:0] sa_x, sb_x, mul_s, sra_s;
  logic                       slt;

  assign zero_h = '0;
  assign sh     = i1[SH_W-1:0];
  assign add_u  = {1'b0, i0} + {1'b0, i1};
  assign sub_u  = {1'b0, i0} - {1'b0, i1};
  // One guard bit of sign: the top two bits differing means signed overflow.
  assign add_s  = $signed({i0[DATA_W-1], i0}) + $signed({i1[DATA_W-1], i1});
  assign sub_s  = $signed({i0[DATA_W-1], i0}) - $signed({i1[DATA_W-1], i1});
  assign sa_x   = $signed({{DATA_W{i0[DATA_W-1]}}, i0});
  assign sb_x   = $signed({{DATA_W{i1[DATA_W-1]}}, i1});
  assign mul_s  = sa_x * sb_x;
  assign sra_s  = sa_x >>> sh;
  assign slt    = $signed(i0) < $signed(i1);

  always_comb begin
    o        = '0;
    overflow = 1'b0;
    cout     = 1'b0;
    case (op)
      OP_ADD: begin
        o        = {{(DATA_W-1){1'b0}}, add_u};
        cout     = add_u[DATA_W];
        overflow = add_s[DATA_W] ^ add_s[DATA_W-1];
      end
      OP_SUB: begin
        o        = {{(DATA_W-1){sub_s[DATA_W]}}, sub_s};
        cout     = sub_u[DATA_W];
        overflow = sub_s[DATA_W] ^ sub_s[DATA_W-1];
      end
      OP_MUL:  o = mul_s;
      OP_AND:  o = {zero_h, i0 & i1};
      OP_OR:   o = {zero_h, i0 | i1};
      OP_XOR:  o = {zero_h, i0 ^ i1};
      OP_NOT:  o = {zero_h, ~i0};
      OP_SHL:  o = {zero_h, i0} << sh;
      OP_SHR:  o = {zero_h, i0 >> sh};
      OP_SRA:  o = sra_s;
      OP_SLT:  o = {{(2*DATA_W-1){1'b0}}, slt};
      default: o = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with
// registered operands and a held, id-tagged response.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_W-1:0]     req0_op,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_W-1:0]     req1_op,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_overflow,
  output logic                rsp_cout,
  output logic                rsp_illegal,
  output logic                busy
);

  localparam logic [OP_W-1:0] OP_LIMIT = OP_W'(NUM_OPS);

  state_t                state_q, state_d;
  logic                  rr_q;
  logic                  gnt1, accept, op_illegal;
  logic                  id_p0;
  logic [OP_W-1:0]       op_p0;
  logic [DATA_W-1:0]     a_p0, b_p0;
  logic                  id_p1, ovf_p1, cout_p1, ill_p1;
  logic [2*DATA_W-1:0]   res_p1;
  logic [2*DATA_W-1:0]   alu_o;
  logic                  alu_ovf, alu_cout;

  // Grant and next state; ready is gated by reset so no grant is shown while held.
  always_comb begin
    gnt1       = req1_valid && (!req0_valid || rr_q);
    accept     = (state_q == ST_IDLE) && reset && (req0_valid || req1_valid);
    req0_ready = accept && !gnt1;
    req1_ready = accept && gnt1;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) rr_q <= !gnt1;
    end
  end

  // Stage p0: granted request captured into the operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_p0 <= 1'b0;
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (accept) begin
      id_p0 <= gnt1;
      op_p0 <= gnt1 ? req1_op : req0_op;
      a_p0  <= gnt1 ? req1_a  : req0_a;
      b_p0  <= gnt1 ? req1_b  : req0_b;
    end
  end

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .i0       (a_p0),
    .i1       (b_p0),
    .op       (op_p0),
    .o        (alu_o),
    .overflow (alu_ovf),
    .cout     (alu_cout)
  );

  assign op_illegal = op_p0 >= OP_LIMIT;

  // Stage p1: ALU output latched at the end of EXEC and held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_p1   <= 1'b0;
      res_p1  <= '0;
      ovf_p1  <= 1'b0;
      cout_p1 <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      id_p1   <= id_p0;
      res_p1  <= op_illegal ? '0 : alu_o;
      ovf_p1  <= !op_illegal && alu_ovf;
      cout_p1 <= !op_illegal && alu_cout;
      ill_p1  <= op_illegal;
    end
  end

  assign rsp_valid    = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_id       = id_p1;
  assign rsp_result   = res_p1;
  assign rsp_overflow = ovf_p1;
  assign rsp_cout     = cout_p1;
  assign rsp_illegal  = ill_p1;

endmodule
